// File: rtl/vjdot_seq_pkg.sv
// Shared encodings for the sequential vj cross-product block.
// Joint types, FSM states and product indices.
package vjdot_seq_pkg;

    localparam logic JTYPE_REV = 1'b0;
    localparam logic JTYPE_PRI = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] P_AX = 2'd0;
    localparam logic [1:0] P_AY = 2'd1;
    localparam logic [1:0] P_LX = 2'd2;
    localparam logic [1:0] P_LY = 2'd3;

endpackage

// File: rtl/vjdot_seq_lane.sv
// One multiplier lane: operand select, sign select, fixed-point multiply.
// Saturating arithmetic when VJDOT_SAT_EN is defined, wrap-around otherwise.
module vjdot_seq_lane
    import vjdot_seq_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DECIMAL_BITS = 16
) (
    input  logic [1:0]       p,
    input  logic             jtype,
    input  logic [WIDTH-1:0] vj,
    input  logic [WIDTH-1:0] ax,
    input  logic [WIDTH-1:0] ay,
    input  logic [WIDTH-1:0] lx,
    input  logic [WIDTH-1:0] ly,
    output logic [WIDTH-1:0] prod,
    output logic             sat
);

    localparam logic [WIDTH-1:0] QMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic                   neg;
    logic                   zero;
    logic                   neg_sat;
    logic [WIDTH-1:0]       b;
    logic [WIDTH-1:0]       vjn;
    logic [WIDTH-1:0]       a;
    logic signed [2*WIDTH-1:0] ae;
    logic signed [2*WIDTH-1:0] be;
    logic signed [2*WIDTH-1:0] full;
    logic signed [2*WIDTH-1:0] shf;

    always_comb begin
        neg  = 1'b0;
        zero = 1'b0;
        b    = '0;
        unique case (p)
            P_AX: begin
                b    = ay;
                zero = (jtype == JTYPE_PRI);
            end
            P_AY: begin
                b    = ax;
                neg  = 1'b1;
                zero = (jtype == JTYPE_PRI);
            end
            P_LX: begin
                b = (jtype == JTYPE_PRI) ? ay : ly;
            end
            P_LY: begin
                b   = (jtype == JTYPE_PRI) ? ax : lx;
                neg = 1'b1;
            end
        endcase
    end

`ifdef VJDOT_SAT_EN
    logic ovf;

    always_comb begin
        vjn     = -vj;
        neg_sat = 1'b0;
        if (neg && vj == QMIN) begin
            vjn     = QMAX;
            neg_sat = 1'b1;
        end
        a    = neg ? vjn : vj;
        ae   = {{WIDTH{a[WIDTH-1]}}, a};
        be   = {{WIDTH{b[WIDTH-1]}}, b};
        full = ae * be;
        shf  = full >>> DECIMAL_BITS;
        // Upper bits must all match the result sign bit to fit
        ovf  = !((&shf[2*WIDTH-1:WIDTH-1]) || !(|shf[2*WIDTH-1:WIDTH-1]));
        prod = shf[WIDTH-1:0];
        if (ovf)
            prod = shf[2*WIDTH-1] ? QMIN : QMAX;
        if (zero)
            prod = '0;
        sat = (ovf || neg_sat) && !zero;
    end
`else
    logic unused_ok;

    always_comb begin
        vjn     = -vj;
        neg_sat = 1'b0;
        a       = neg ? vjn : vj;
        ae      = {{WIDTH{a[WIDTH-1]}}, a};
        be      = {{WIDTH{b[WIDTH-1]}}, b};
        full    = ae * be;
        shf     = full >>> DECIMAL_BITS;
        prod    = zero ? '0 : shf[WIDTH-1:0];
        sat     = 1'b0;
    end

    assign unused_ok = ^{shf[2*WIDTH-1:WIDTH], neg_sat, QMAX, QMIN};
`endif

endmodule

// File: rtl/vjdot_seq.sv
// Time-multiplexed vj cross product (vjval x colvec) with valid/ready on both sides.
// Optional clamp arithmetic and sat_flag_out enabled by defining VJDOT_SAT_EN.
module vjdot_seq
    import vjdot_seq_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DECIMAL_BITS = 16,
    parameter int NUM_MULT     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             jtype_in,
    input  logic [WIDTH-1:0] vjval_in,
    input  logic [WIDTH-1:0] colvec_in_AX,
    input  logic [WIDTH-1:0] colvec_in_AY,
    input  logic [WIDTH-1:0] colvec_in_AZ,
    input  logic [WIDTH-1:0] colvec_in_LX,
    input  logic [WIDTH-1:0] colvec_in_LY,
    input  logic [WIDTH-1:0] colvec_in_LZ,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] vjvec_out_AX,
    output logic [WIDTH-1:0] vjvec_out_AY,
    output logic [WIDTH-1:0] vjvec_out_AZ,
    output logic [WIDTH-1:0] vjvec_out_LX,
    output logic [WIDTH-1:0] vjvec_out_LY,
    output logic [WIDTH-1:0] vjvec_out_LZ,
    output logic             sat_flag_out
);

    localparam int NPASS = 4 / NUM_MULT;

    state_t           state;
    logic [1:0]       pass;
    logic             jtype_q;
    logic [WIDTH-1:0] vj_q;
    logic [WIDTH-1:0] ax_q;
    logic [WIDTH-1:0] ay_q;
    logic [WIDTH-1:0] lx_q;
    logic [WIDTH-1:0] ly_q;
    logic             sat_q;
    logic             accept;
    logic             last;
    logic             lane_sat;
    logic [WIDTH-1:0] res  [4];
    logic [WIDTH-1:0] nres [4];
    logic [WIDTH-1:0] prod [NUM_MULT];
    logic [1:0]       lane_p [NUM_MULT];
    logic [NUM_MULT-1:0] lsat;
    logic             unused_ok;

    assign in_ready = !reset &&
        (state == S_IDLE || (state == S_DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign last     = (pass == 2'(NPASS - 1));
    assign lane_sat = |lsat;

    assign vjvec_out_AZ = '0;
    assign vjvec_out_LZ = '0;
    assign unused_ok    = ^{colvec_in_AZ, colvec_in_LZ};

    for (genvar l = 0; l < NUM_MULT; l++) begin : g_lane
        assign lane_p[l] = 2'(int'(pass) * NUM_MULT + l);

        vjdot_seq_lane #(
            .WIDTH        (WIDTH),
            .DECIMAL_BITS (DECIMAL_BITS)
        ) u_lane (
            .p     (lane_p[l]),
            .jtype (jtype_q),
            .vj    (vj_q),
            .ax    (ax_q),
            .ay    (ay_q),
            .lx    (lx_q),
            .ly    (ly_q),
            .prod  (prod[l]),
            .sat   (lsat[l])
        );
    end

    // Merge this pass's lane products over the stored results
    always_comb begin
        for (int i = 0; i < 4; i++)
            nres[i] = res[i];
        for (int l = 0; l < NUM_MULT; l++)
            nres[lane_p[l]] = prod[l];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            pass         <= '0;
            sat_q        <= 1'b0;
            out_valid    <= 1'b0;
            sat_flag_out <= 1'b0;
            vjvec_out_AX <= '0;
            vjvec_out_AY <= '0;
            vjvec_out_LX <= '0;
            vjvec_out_LY <= '0;
            jtype_q      <= JTYPE_REV;
            vj_q         <= '0;
            ax_q         <= '0;
            ay_q         <= '0;
            lx_q         <= '0;
            ly_q         <= '0;
            for (int i = 0; i < 4; i++)
                res[i] <= '0;
        end else begin
            if (accept) begin
                jtype_q <= jtype_in;
                vj_q    <= vjval_in;
                ax_q    <= colvec_in_AX;
                ay_q    <= colvec_in_AY;
                lx_q    <= colvec_in_LX;
                ly_q    <= colvec_in_LY;
                pass    <= '0;
                sat_q   <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (accept)
                        state <= S_CALC;
                end
                S_CALC: begin
                    for (int i = 0; i < 4; i++)
                        res[i] <= nres[i];
                    sat_q <= sat_q || lane_sat;
                    if (last) begin
                        state        <= S_DONE;
                        pass         <= '0;
                        out_valid    <= 1'b1;
                        sat_flag_out <= sat_q || lane_sat;
                        vjvec_out_AX <= nres[P_AX];
                        vjvec_out_AY <= nres[P_AY];
                        vjvec_out_LX <= nres[P_LX];
                        vjvec_out_LY <= nres[P_LY];
                    end else begin
                        pass <= pass + 2'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= accept ? S_CALC : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vjdot_seq.sv
// Bench for vjdot_seq: cycle-level behavioural model plus directed literal checks.
// Honours VJDOT_SAT_EN for clamp expectations; NUM_MULT set by parameter.
module tb_vjdot_seq #(
    parameter int NUM_MULT = 1
);

    localparam int NPASS = 4 / NUM_MULT;
    localparam longint QMAX = 64'sd2147483647;
    localparam longint QMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        jtype_in;
    logic [31:0] vjval_in;
    logic [31:0] c_ax, c_ay, c_az, c_lx, c_ly, c_lz;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] o_ax, o_ay, o_az, o_lx, o_ly, o_lz;
    logic        sat_flag_out;

    int n_cmp = 0;
    int n_bad = 0;

    vjdot_seq #(
        .WIDTH(32), .DECIMAL_BITS(16), .NUM_MULT(NUM_MULT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .jtype_in     (jtype_in),
        .vjval_in     (vjval_in),
        .colvec_in_AX (c_ax),
        .colvec_in_AY (c_ay),
        .colvec_in_AZ (c_az),
        .colvec_in_LX (c_lx),
        .colvec_in_LY (c_ly),
        .colvec_in_LZ (c_lz),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .vjvec_out_AX (o_ax),
        .vjvec_out_AY (o_ay),
        .vjvec_out_AZ (o_az),
        .vjvec_out_LX (o_lx),
        .vjvec_out_LY (o_ly),
        .vjvec_out_LZ (o_lz),
        .sat_flag_out (sat_flag_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Fixed-point arithmetic straight from the number format
    function automatic logic [31:0] mulq(input logic [31:0] a,
                                         input logic [31:0] b,
                                         inout bit s);
        longint f;
        f = longint'($signed(a)) * longint'($signed(b));
        f = f >>> 16;
`ifdef VJDOT_SAT_EN
        if (f > QMAX) begin s = 1; return 32'h7FFFFFFF; end
        if (f < QMIN) begin s = 1; return 32'h80000000; end
`endif
        return 32'(f);
    endfunction

    function automatic logic [31:0] negq(input logic [31:0] a,
                                         inout bit s);
`ifdef VJDOT_SAT_EN
        if (a == 32'h80000000) begin s = 1; return 32'h7FFFFFFF; end
`endif
        return -a;
    endfunction

    function automatic void calc(input bit jt, input logic [31:0] vj,
                                 input logic [31:0] ax, input logic [31:0] ay,
                                 input logic [31:0] lx, input logic [31:0] ly,
                                 output logic [3:0][31:0] r, output bit s);
        logic [31:0] nv;
        s = 0;
        r = '0;
        if (!jt) begin
            nv   = negq(vj, s);
            r[0] = mulq(vj, ay, s);
            r[1] = mulq(nv, ax, s);
            r[2] = mulq(vj, ly, s);
            r[3] = mulq(nv, lx, s);
        end else begin
            nv   = negq(vj, s);
            r[2] = mulq(vj, ay, s);
            r[3] = mulq(nv, ax, s);
        end
    endfunction

    // Cycle model: a result appears NPASS edges after accept
    bit              m_init = 0;
    bit              m_pend, m_valid, m_sat, m_nsat;
    int              m_cnt;
    logic [3:0][31:0] m_out, m_next;

    always @(posedge clk) begin
        bit rdy, acc;
        m_init = 1;
        if (reset) begin
            m_pend  = 0;
            m_valid = 0;
            m_sat   = 0;
            m_cnt   = 0;
            m_out   = '0;
        end else begin
            rdy = (!m_pend && !m_valid) || (m_valid && out_ready);
            acc = in_valid && rdy;
            if (m_valid && out_ready)
                m_valid = 0;
            if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_pend  = 0;
                    m_valid = 1;
                    m_out   = m_next;
                    m_sat   = m_nsat;
                end
            end
            if (acc) begin
                m_pend = 1;
                m_cnt  = NPASS;
                calc(jtype_in, vjval_in, c_ax, c_ay, c_lx, c_ly,
                     m_next, m_nsat);
            end
        end
    end

    always @(negedge clk) begin
        bit er;
        if (m_init) begin
            er = !reset && ((!m_pend && !m_valid) ||
                            (m_valid && out_ready));
            chk("in_ready", {31'b0, in_ready}, {31'b0, er});
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            chk("AX", o_ax, m_out[0]);
            chk("AY", o_ay, m_out[1]);
            chk("AZ", o_az, 32'h0);
            chk("LX", o_lx, m_out[2]);
            chk("LY", o_ly, m_out[3]);
            chk("LZ", o_lz, 32'h0);
            chk("sat", {31'b0, sat_flag_out}, {31'b0, m_sat});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit jt, input logic [31:0] vj,
                         input logic [31:0] ax, input logic [31:0] ay,
                         input logic [31:0] lx, input logic [31:0] ly);
        jtype_in = jt;
        vjval_in = vj;
        c_ax = ax;
        c_ay = ay;
        c_lx = lx;
        c_ly = ly;
        c_az = $urandom;
        c_lz = $urandom;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk(name, n, NPASS);
    endtask

    task automatic issue(input bit jt, input logic [31:0] vj,
                         input logic [31:0] ax, input logic [31:0] ay,
                         input logic [31:0] lx, input logic [31:0] ly);
        drive(jt, vj, ax, ay, lx, ly);
        in_valid = 1;
        tick();
        in_valid = 0;
    endtask

    logic [31:0] vec_vj [6] = '{32'hFFFE8000, 32'h80000000, 32'h00010000,
                                32'h7FFFFFFF, 32'h00001234, 32'hC0000000};
    logic [31:0] vec_c  [6] = '{32'h00020000, 32'h00010000, 32'hFFFF0000,
                                32'h00018000, 32'h89ABCDEF, 32'h00000100};
    bit          vec_jt [6] = '{0, 0, 1, 0, 1, 0};

    initial begin
        int n;
        logic [31:0] h_ax, h_ly;
        reset = 1;
        in_valid = 0;
        out_ready = 0;
        drive(0, '0, '0, '0, '0, '0);
        repeat (3) tick();
        reset = 0;
        #1;
        chk("ready_after_reset", {31'b0, in_ready}, 32'd1);

        // 1 revolute
        issue(0, 32'h00020000, 32'h00010000, 32'h00030000,
              32'hFFFF8000, 32'h00004000);
        wait_valid("lat_rev", n);
        chk("t1_AX", o_ax, 32'h00060000);
        chk("t1_AY", o_ay, 32'hFFFE0000);
        chk("t1_LX", o_lx, 32'h00008000);
        chk("t1_LY", o_ly, 32'h00010000);
        out_ready = 1;
        tick();
        out_ready = 0;

        // 2 prismatic
        issue(1, 32'h00020000, 32'h00010000, 32'h00030000,
              32'hFFFF8000, 32'h00004000);
        wait_valid("lat_pri", n);
        chk("t2_AX", o_ax, 32'h0);
        chk("t2_AY", o_ay, 32'h0);
        chk("t2_LX", o_lx, 32'h00060000);
        chk("t2_LY", o_ly, 32'hFFFE0000);

        // 3 backpressure with back-to-back accept
        h_ax = o_ax;
        h_ly = o_ly;
        repeat (10) begin
            tick();
            chk("bp_AX", o_ax, h_ax);
            chk("bp_LY", o_ly, h_ly);
            chk("bp_ready", {31'b0, in_ready}, 32'd0);
        end
        drive(0, 32'h00010000, 32'h00050000, 32'h00020000,
              32'h00010000, 32'h00030000);
        in_valid = 1;
        out_ready = 1;
        #1;
        chk("b2b_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 0;
        out_ready = 0;
        wait_valid("lat_b2b", n);
        chk("t3_AX", o_ax, 32'h00020000);
        chk("t3_AY", o_ay, 32'hFFFB0000);
        out_ready = 1;
        tick();
        out_ready = 0;

        // 4 reset during the second compute cycle
        issue(0, 32'h00020000, 32'h00010000, 32'h00030000,
              32'hFFFF8000, 32'h00004000);
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_AX", o_ax, 32'h0);
        #1;
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        repeat (6) begin
            tick();
            chk("rst_no_stale", {31'b0, out_valid}, 32'd0);
        end

        // 5 overflow
        issue(0, 32'h7FFF0000, 32'h0, 32'h00040000, 32'h0, 32'h0);
        wait_valid("lat_ovf", n);
`ifdef VJDOT_SAT_EN
        chk("t5_AX", o_ax, 32'h7FFFFFFF);
        chk("t5_sat", {31'b0, sat_flag_out}, 32'd1);
`else
        chk("t5_AX", o_ax, 32'hFFFC0000);
        chk("t5_sat", {31'b0, sat_flag_out}, 32'd0);
`endif
        out_ready = 1;
        tick();
        out_ready = 0;

        // 6 operand changes while busy are ignored
        issue(0, 32'h00020000, 32'h00010000, 32'h00030000,
              32'hFFFF8000, 32'h00004000);
        drive(1, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0);
        wait_valid("lat_chg", n);
        chk("t6_AX", o_ax, 32'h00060000);
        chk("t6_LY", o_ly, 32'h00010000);

        // streaming with consumer always ready
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            drive(vec_jt[i], vec_vj[i], vec_c[i], vec_c[(i+1)%6],
                  vec_c[(i+2)%6], vec_c[(i+3)%6]);
            in_valid = 1;
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            chk("stream_wait", {31'b0, in_ready}, 32'd1);
            tick();
        end
        in_valid = 0;
        repeat (NPASS + 3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout, %0d compared / %0d mismatched",
                 n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
